// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Pixel request / colour return / VGA output bundle for the
//               raster generator. The master side is the timing generator.
// Revision    : 1.0  initial release
// ============================================================================
interface vga_timing_gen_if #(
  parameter int COLOR_W = 4
);
  logic               pix_en;
  logic               pix_req;
  logic [10:0]        req_x;
  logic [9:0]         req_y;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;
  logic               VGA_HS;
  logic               VGA_VS;
  logic               frame_start;

  modport master (
    output pix_en, pix_req, req_x, req_y,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_start,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  pix_en, pix_req, req_x, req_y,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_start,
    output pix_r, pix_g, pix_b
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster counter, sync generator and one-slot
//               pixel pipeline with forced blanking.
// Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CLK_DIV  = 1,
  parameter int COLOR_W  = 4
) (
  input  wire logic        MAX10_CLK1_50,
  input  wire logic        reset,
  vga_timing_gen_if.master vga
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CLK_DIV < 1 || COLOR_W < 1 ||
        c_h_total > 2048 || c_v_total > 1024) begin : g_bad_params
      $error("vga_timing_gen: illegal timing parameters");
    end
  endgenerate

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [10:0] c_h_last     = 11'(c_h_total - 1);
  localparam logic [10:0] c_h_act      = 11'(H_ACTIVE);
  localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  c_v_last     = 10'(c_v_total - 1);
  localparam logic [9:0]  c_v_act      = 10'(V_ACTIVE);
  localparam logic [9:0]  c_vs_start   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  c_vs_end     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [c_div_w-1:0] r_div_cnt;
  logic [10:0]        r_h_cnt;
  logic [9:0]         r_v_cnt;
  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_grn;
  logic [COLOR_W-1:0] r_blu;
  logic               r_hs;
  logic               r_vs;
  logic               r_frame_start;

  logic w_pix_en;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_pix_req;
  logic w_hs_act;
  logic w_vs_act;

  assign w_pix_en = (r_div_cnt == c_div_last);
  assign w_h_wrap = (r_h_cnt == c_h_last);
  assign w_v_wrap = (r_v_cnt == c_v_last);

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_pix_en) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + c_div_w'(1);
    end
  end

  // The vertical counter only advances on the horizontal wrap slot.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_en) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
    end
  end

  always_comb begin
    w_pix_req = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act) && !reset;
    w_hs_act  = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    w_vs_act  = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
  end

  // Colour and sync share one register stage so they stay slot-aligned.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_red         <= '0;
      r_grn         <= '0;
      r_blu         <= '0;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_en && w_h_wrap && w_v_wrap;
      if (w_pix_en) begin
        r_red <= w_pix_req ? vga.pix_r : '0;
        r_grn <= w_pix_req ? vga.pix_g : '0;
        r_blu <= w_pix_req ? vga.pix_b : '0;
        r_hs  <= w_hs_act ? HS_POL : ~HS_POL;
        r_vs  <= w_vs_act ? VS_POL : ~VS_POL;
      end
    end
  end

  assign vga.pix_en      = w_pix_en;
  assign vga.pix_req     = w_pix_req;
  assign vga.req_x       = w_pix_req ? r_h_cnt : 11'd0;
  assign vga.req_y       = w_pix_req ? r_v_cnt : 10'd0;
  assign vga.VGA_R       = r_red;
  assign vga.VGA_G       = r_grn;
  assign vga.VGA_B       = r_blu;
  assign vga.VGA_HS      = r_hs;
  assign vga.VGA_VS      = r_vs;
  assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire
